fetch_request_scheduler: RTL and testbench

- Sequences instruction-fetch requests from the fetch PC to the instruction memory port.
- Tracks instruction-buffer occupancy plus in-flight requests as a credit count, so the buffer can never overflow.
- Tags each response with its PC and forwards it to the instruction buffer write port.
- On a pipeline flush, redirects the PC and discards stale in-flight responses.

---
 rtl/fetch_request_scheduler.sv | 89 ++++++++
 tb/tb_fetch_request_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_request_scheduler.sv
// fetch_request_scheduler: credit-limited instruction fetch issue with PC-tagged responses and flush drain
module fetch_request_scheduler #(
  parameter logic [31:0] P_RESET_PC        = 32'h0000_0000,
  parameter int          P_BUF_DEPTH       = 32,
  parameter int          P_MAX_OUTSTANDING = 4,
  parameter int          P_CNT_W           = 6
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iFLUSH,
  input  logic [31:0]        iFLUSH_PC,
  input  logic               iSTALL,
  output logic               oREQ_VALID,
  output logic [31:0]        oREQ_ADDR,
  input  logic               iREQ_BUSY,
  input  logic               iRSP_VALID,
  input  logic [31:0]        iRSP_INST,
  output logic               oBUF_WR_EN,
  output logic [31:0]        oBUF_WR_INST,
  output logic [31:0]        oBUF_WR_PC,
  input  logic               iBUF_POP,
  output logic               oBUF_FLUSH,
  output logic [3:0]         oOUTSTANDING,
  output logic [P_CNT_W-1:0] oCREDITS,
  output logic               oDRAINING
);
  typedef enum logic {RUN, DRAIN} state_t;
  localparam logic [2:0]         QM    = 3'(P_MAX_OUTSTANDING - 1);
  localparam logic [3:0]         MAXO  = 4'(P_MAX_OUTSTANDING);
  localparam logic [P_CNT_W-1:0] DEPTH = P_CNT_W'(P_BUF_DEPTH);
  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [P_CNT_W-1:0] buf_q, buf_d;
  logic [3:0]         out_q, out_d, disc_q, disc_d;
  logic [2:0]         wp_q, wp_d, rp_q, rp_d;
  logic [31:0]        addr_q [0:7];
  logic               rsp, acc, wr, pop;
  // Pointers run mod 8 and are masked to the queue depth, which divides 8.
  assign oCREDITS     = DEPTH - buf_q - P_CNT_W'(out_q);
  assign rsp          = iRSP_VALID && out_q != 4'd0;
  assign oREQ_VALID   = inRESET && state_q == RUN && !iSTALL && !iFLUSH && oCREDITS != '0 && out_q < MAXO;
  assign acc          = oREQ_VALID && !iREQ_BUSY;
  assign wr           = inRESET && rsp && disc_q == 4'd0 && !iFLUSH;
  assign pop          = iBUF_POP && buf_q != '0;
  assign oREQ_ADDR    = pc_q;
  assign oBUF_WR_EN   = wr;
  assign oBUF_WR_INST = iRSP_INST;
  assign oBUF_WR_PC   = addr_q[rp_q & QM];
  assign oBUF_FLUSH   = iFLUSH;
  assign oOUTSTANDING = out_q;
  assign oDRAINING    = state_q == DRAIN;
  // Next-state: counters, PC redirect and discard bookkeeping for stale responses.
  always_comb begin
    out_d   = out_q + {3'b0, acc} - {3'b0, rsp};
    disc_d  = iFLUSH ? out_q - {3'b0, rsp} : disc_q - {3'b0, rsp && disc_q != 4'd0};
    buf_d   = iFLUSH ? '0 : (wr && iBUF_POP) ? buf_q : wr ? buf_q + 1'b1 : pop ? buf_q - 1'b1 : buf_q;
    pc_d    = iFLUSH ? iFLUSH_PC : acc ? pc_q + 32'd4 : pc_q;
    wp_d    = wp_q + {2'b0, acc};
    rp_d    = rp_q + {2'b0, rsp};
    state_d = disc_d != 4'd0 ? DRAIN : RUN;
  end
  // State register: RUN issues, DRAIN blocks issue until every stale response is dropped.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q <= RUN;
      pc_q    <= P_RESET_PC;
      buf_q   <= '0;
      out_q   <= 4'd0;
      disc_q  <= 4'd0;
      wp_q    <= 3'd0;
      rp_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end
  // Address queue: remembers the PC of each accepted request to tag its response.
  always_ff @(posedge iCLOCK) begin
    if (acc) addr_q[wp_q & QM] <= pc_q;
  end
`ifdef MIST1032ISA_SVA_ASSERTION
  a_rsp_without_request: assert property (@(posedge iCLOCK) disable iff (!inRESET) !(iRSP_VALID && out_q == 4'd0));
`endif
endmodule

// File: tb/tb_fetch_request_scheduler.sv
// tb_fetch_request_scheduler: directed checks of issue, credits, response tagging, flush drain and reset
module tb_fetch_request_scheduler;
  logic        clk = 1'b0;
  logic        inRESET, iFLUSH, iSTALL, iREQ_BUSY, iRSP_VALID, iBUF_POP;
  logic [31:0] iFLUSH_PC, iRSP_INST;
  logic        oREQ_VALID, oBUF_WR_EN, oBUF_FLUSH, oDRAINING;
  logic [31:0] oREQ_ADDR, oBUF_WR_INST, oBUF_WR_PC;
  logic [3:0]  oOUTSTANDING;
  logic [5:0]  oCREDITS;
  int          checks = 0, errors = 0;
  int          wcnt, acnt, outs, bufd, disc;
  logic [31:0] exp_addr, q[$];
  logic [1:0]  pipe;
  bit          auto_rsp, mon;
  always #5 clk = ~clk;
  fetch_request_scheduler dut (
    .iCLOCK(clk), .inRESET(inRESET), .iFLUSH(iFLUSH), .iFLUSH_PC(iFLUSH_PC), .iSTALL(iSTALL),
    .oREQ_VALID(oREQ_VALID), .oREQ_ADDR(oREQ_ADDR), .iREQ_BUSY(iREQ_BUSY),
    .iRSP_VALID(iRSP_VALID), .iRSP_INST(iRSP_INST), .oBUF_WR_EN(oBUF_WR_EN),
    .oBUF_WR_INST(oBUF_WR_INST), .oBUF_WR_PC(oBUF_WR_PC), .iBUF_POP(iBUF_POP),
    .oBUF_FLUSH(oBUF_FLUSH), .oOUTSTANDING(oOUTSTANDING), .oCREDITS(oCREDITS), .oDRAINING(oDRAINING)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One clock: check the current cycle against the model, then advance model and memory responder.
  task automatic tick();
    logic ev, wr, acc, rsp;
    int   cred;
    #1;
    cred = 32 - bufd - outs;
    ev   = inRESET && disc == 0 && !iSTALL && !iFLUSH && cred > 0 && outs < 4;
    wr   = inRESET && iRSP_VALID && outs > 0 && disc == 0 && !iFLUSH;
    if (mon) begin
      chk("req_valid", oREQ_VALID, ev);
      if (ev) chk("req_addr", oREQ_ADDR, exp_addr);
      chk("wr_en", oBUF_WR_EN, wr);
      if (wr) begin
        chk("wr_pc", oBUF_WR_PC, q[0]);
        chk("wr_inst", oBUF_WR_INST, ~q[0]);
      end
      chk("outstanding", oOUTSTANDING, outs);
      chk("credits", oCREDITS, cred);
      chk("draining", oDRAINING, disc != 0);
      chk("buf_flush", oBUF_FLUSH, iFLUSH);
    end
    if (oBUF_WR_EN) wcnt++;
    if (oREQ_VALID && !iREQ_BUSY) acnt++;
    acc = ev && !iREQ_BUSY;
    rsp = iRSP_VALID && outs > 0;
    @(posedge clk);
    if (!inRESET) begin
      outs = 0; bufd = 0; disc = 0; exp_addr = 32'h0; pipe = 2'b00;
      q.delete();
    end else begin
      if (acc) q.push_back(exp_addr);
      if (rsp) void'(q.pop_front());
      if (iFLUSH) begin
        bufd = 0;
        disc = outs - int'(rsp);
        exp_addr = iFLUSH_PC;
      end else begin
        if (wr && !iBUF_POP) bufd++;
        else if (!wr && iBUF_POP && bufd > 0) bufd--;
        if (rsp && disc > 0) disc--;
        if (acc) exp_addr += 32'd4;
      end
      outs += int'(acc) - int'(rsp);
      pipe = {pipe[0], acc};
    end
    #1;
    if (auto_rsp) iRSP_VALID = pipe[1];
    iRSP_INST = q.size() > 0 ? ~q[0] : 32'h0;
  endtask
  task automatic do_reset();
    inRESET = 1'b0; iFLUSH = 1'b0; iSTALL = 1'b0; iREQ_BUSY = 1'b0;
    iRSP_VALID = 1'b0; iBUF_POP = 1'b0; iFLUSH_PC = 32'h0;
    auto_rsp = 1'b0;
    tick();
    tick();
    inRESET = 1'b1;
    wcnt = 0; acnt = 0;
  endtask
  initial begin
    mon = 1'b0;
    outs = 0; bufd = 0; disc = 0; exp_addr = 32'h0; pipe = 2'b00;
    iRSP_INST = 32'h0;
    inRESET = 1'b0; iFLUSH = 1'b0; iSTALL = 1'b0; iREQ_BUSY = 1'b0;
    iRSP_VALID = 1'b0; iBUF_POP = 1'b0; iFLUSH_PC = 32'h0;
    auto_rsp = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_req_valid", oREQ_VALID, 0);
    chk("rst_wr_en", oBUF_WR_EN, 0);
    chk("rst_draining", oDRAINING, 0);
    chk("rst_outstanding", oOUTSTANDING, 0);
    chk("rst_credits", oCREDITS, 32);
    inRESET = 1'b1;
    mon = 1'b1;
    // Streaming fetch: responses two cycles after accept, no pops, fills exactly 32 entries.
    do_reset();
    auto_rsp = 1'b1;
    #1 chk("t1_first_addr", oREQ_ADDR, 32'h0);
    for (int i = 0; i < 200 && wcnt < 32; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("t1_writes", wcnt, 32);
    chk("t1_req_valid_full", oREQ_VALID, 0);
    chk("t1_credits_full", oCREDITS, 0);
    // Silent memory: only four requests fit in flight.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("t2_accepts", acnt, 4);
    chk("t2_outstanding", oOUTSTANDING, 4);
    chk("t2_req_valid", oREQ_VALID, 0);
    // Flush with three in flight and a response in the flush cycle.
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    iREQ_BUSY = 1'b1;
    #1 chk("t3_outstanding", oOUTSTANDING, 3);
    iFLUSH = 1'b1; iFLUSH_PC = 32'h100; iRSP_VALID = 1'b1;
    #1;
    chk("t3_flush_out", oBUF_FLUSH, 1);
    chk("t3_flush_wr", oBUF_WR_EN, 0);
    tick();
    iFLUSH = 1'b0; iRSP_VALID = 1'b0;
    #1;
    chk("t3_draining", oDRAINING, 1);
    chk("t3_out_after", oOUTSTANDING, 2);
    chk("t3_cred_after", oCREDITS, 30);
    iRSP_VALID = 1'b1;
    #1 chk("t3_drop1", oBUF_WR_EN, 0);
    tick();
    #1 chk("t3_drop2", oBUF_WR_EN, 0);
    tick();
    iRSP_VALID = 1'b0; iREQ_BUSY = 1'b0;
    #1;
    chk("t3_drain_done", oDRAINING, 0);
    chk("t3_new_valid", oREQ_VALID, 1);
    chk("t3_new_addr", oREQ_ADDR, 32'h100);
    tick();
    // Near-full buffer: write and pop in the same cycle keep 31 entries, then random pops.
    do_reset();
    auto_rsp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bufd == 31 && iRSP_VALID) break;
      tick();
    end
    #1 chk("t4_reach31_cred", oCREDITS, 0);
    iBUF_POP = 1'b1;
    tick();
    iBUF_POP = 1'b0;
    #1;
    chk("t4_cred_after_tie", oCREDITS, 1);
    chk("t4_out_after_tie", oOUTSTANDING, 0);
    for (int i = 0; i < 200; i++) begin
      iBUF_POP = 1'($urandom_range(0, 1));
      tick();
    end
    iBUF_POP = 1'b0;
    tick();
    // Stall with two in flight: responses still land, issue resumes at the next PC.
    do_reset();
    tick();
    tick();
    iSTALL = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 10; k++) begin
      iRSP_VALID = (k == 3 || k == 6);
      #1 if (k == 0) chk("t5_stall_blocks", oREQ_VALID, 0);
      tick();
    end
    iSTALL = 1'b0; iRSP_VALID = 1'b0;
    #1;
    chk("t5_writes", wcnt, 2);
    chk("t5_resume_valid", oREQ_VALID, 1);
    chk("t5_resume_addr", oREQ_ADDR, 32'h8);
    tick();
    // Reset while draining.
    do_reset();
    tick();
    tick();
    iREQ_BUSY = 1'b1;
    iFLUSH = 1'b1; iFLUSH_PC = 32'h200;
    tick();
    iFLUSH = 1'b0;
    #1 chk("t6_draining", oDRAINING, 1);
    inRESET = 1'b0;
    tick();
    #1;
    chk("t6_rst_draining", oDRAINING, 0);
    chk("t6_rst_outstanding", oOUTSTANDING, 0);
    chk("t6_rst_credits", oCREDITS, 32);
    inRESET = 1'b1; iREQ_BUSY = 1'b0;
    #1;
    chk("t6_first_valid", oREQ_VALID, 1);
    chk("t6_first_addr", oREQ_ADDR, 32'h0);
    tick();
    #1 chk("t6_outstanding", oOUTSTANDING, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
